// File: rtl/jtcontra_gfx_romarb_if.sv
// Request/response bundle between the tilemap and sprite fetchers, the graphics ROM
// arbiter and the SDRAM slot. The arbiter uses the slave view, its environment the master view.
interface jtcontra_gfx_romarb_if #(
  parameter int AW = 18,
  parameter int DW = 16
);
  logic [1:0]    gfx_en;
  logic          scr_cs;
  logic [AW-1:0] scr_addr;
  logic          scr_ok;
  logic [DW-1:0] scr_data;
  logic          obj_cs;
  logic [AW-1:0] obj_addr;
  logic          obj_ok;
  logic [DW-1:0] obj_data;
  logic          rom_cs;
  logic [AW-1:0] rom_addr;
  logic          rom_obj_sel;
  logic [DW-1:0] rom_data;
  logic          rom_ok;
  logic          busy;

  modport master (
    output gfx_en, scr_cs, scr_addr, obj_cs, obj_addr, rom_data, rom_ok,
    input  scr_ok, scr_data, obj_ok, obj_data, rom_cs, rom_addr, rom_obj_sel, busy
  );

  modport slave (
    input  gfx_en, scr_cs, scr_addr, obj_cs, obj_addr, rom_data, rom_ok,
    output scr_ok, scr_data, obj_ok, obj_data, rom_cs, rom_addr, rom_obj_sel, busy
  );
endinterface

// File: rtl/jtcontra_gfx_romarb.sv
// Shares one 007121 graphics ROM SDRAM slot between the tilemap (scr) and sprite (obj) fetchers.
// Define JTCONTRA_ROMARB_RR_EN for strict round-robin; default is scr priority with STARVE limit.
module jtcontra_gfx_romarb #(
  parameter int AW     = 18,
  parameter int DW     = 16,
  parameter int STARVE = 4
)(
  input logic rst,
  input logic clk,
  jtcontra_gfx_romarb_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t        state;
  logic          scr_cs_l, obj_cs_l;
  logic [AW-1:0] scr_addr_l, obj_addr_l;
  logic          scr_pend, obj_pend;
  logic          scr_new, obj_new, scr_pnd, obj_pnd;
  logic          scr_req, obj_req, pick_obj, abort;

`ifdef JTCONTRA_ROMARB_RR_EN
  logic last_obj;
`else
  localparam int            SW         = $clog2(STARVE + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE);
  logic [SW-1:0] starve_cnt;
`endif

  always_comb begin
    // A new request is a cs rising edge or an address change while cs stays high
    scr_new  = bus.scr_cs & (~scr_cs_l | (bus.scr_addr != scr_addr_l));
    obj_new  = bus.obj_cs & (~obj_cs_l | (bus.obj_addr != obj_addr_l));
    scr_pnd  = bus.scr_cs & (scr_pend | scr_new);
    obj_pnd  = bus.obj_cs & (obj_pend | obj_new);
    scr_req  = scr_pnd & bus.gfx_en[0];
    obj_req  = obj_pnd & bus.gfx_en[1];
`ifdef JTCONTRA_ROMARB_RR_EN
    pick_obj = obj_req & (~scr_req | ~last_obj);
`else
    pick_obj = obj_req & (~scr_req | (starve_cnt >= STARVE_MAX));
`endif
    // The winner withdrawing or moving its address invalidates the access in flight
    abort    = bus.rom_obj_sel ? (~bus.obj_cs | obj_new) : (~bus.scr_cs | scr_new);
  end

  always_ff @(posedge clk, posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      scr_cs_l        <= 1'b0;
      obj_cs_l        <= 1'b0;
      scr_addr_l      <= '0;
      obj_addr_l      <= '0;
      scr_pend        <= 1'b0;
      obj_pend        <= 1'b0;
      bus.scr_ok      <= 1'b0;
      bus.scr_data    <= '0;
      bus.obj_ok      <= 1'b0;
      bus.obj_data    <= '0;
      bus.rom_cs      <= 1'b0;
      bus.rom_addr    <= '0;
      bus.rom_obj_sel <= 1'b0;
      bus.busy        <= 1'b0;
`ifdef JTCONTRA_ROMARB_RR_EN
      last_obj        <= 1'b1;
`else
      starve_cnt      <= '0;
`endif
    end else begin
      scr_cs_l   <= bus.scr_cs;
      obj_cs_l   <= bus.obj_cs;
      scr_addr_l <= bus.scr_addr;
      obj_addr_l <= bus.obj_addr;

      // NOTE: non-blocking assignments; a later assignment to the same register in this
      // block takes precedence, so grant/serve updates below override these defaults.
      if (!bus.scr_cs)     scr_pend <= 1'b0;
      else if (scr_new)    scr_pend <= 1'b1;
      if (!bus.obj_cs)     obj_pend <= 1'b0;
      else if (obj_new)    obj_pend <= 1'b1;
      if (!bus.scr_cs || scr_new) bus.scr_ok <= 1'b0;
      if (!bus.obj_cs || obj_new) bus.obj_ok <= 1'b0;

      case (state)
        IDLE: begin
          // Disabled requesters are answered with zeros without touching the SDRAM
          if (scr_pnd && !bus.gfx_en[0]) begin
            bus.scr_ok   <= 1'b1;
            bus.scr_data <= '0;
            scr_pend     <= 1'b0;
          end
          if (obj_pnd && !bus.gfx_en[1]) begin
            bus.obj_ok   <= 1'b1;
            bus.obj_data <= '0;
            obj_pend     <= 1'b0;
          end
          if (scr_req || obj_req) begin
            state           <= ISSUE;
            bus.rom_cs      <= 1'b1;
            bus.busy        <= 1'b1;
            bus.rom_obj_sel <= pick_obj;
            bus.rom_addr    <= pick_obj ? bus.obj_addr : bus.scr_addr;
            if (pick_obj) obj_pend <= 1'b0;
            else          scr_pend <= 1'b0;
`ifdef JTCONTRA_ROMARB_RR_EN
            last_obj <= pick_obj;
`else
            if (pick_obj)     starve_cnt <= '0;
            else if (obj_req) starve_cnt <= starve_cnt + 1'b1;
`endif
          end
        end
        ISSUE, WAIT: begin
          // rom_ok during ISSUE still belongs to the previous address and is ignored
          if (abort || (state == WAIT && bus.rom_ok)) begin
            state           <= IDLE;
            bus.rom_cs      <= 1'b0;
            bus.busy        <= 1'b0;
            bus.rom_obj_sel <= 1'b0;
            if (!abort) begin
              if (bus.rom_obj_sel) begin
                bus.obj_ok   <= 1'b1;
                bus.obj_data <= bus.rom_data;
              end else begin
                bus.scr_ok   <= 1'b1;
                bus.scr_data <= bus.rom_data;
              end
            end
          end else if (state == ISSUE) begin
            state <= WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtcontra_gfx_romarb.sv
// Directed-vector bench for jtcontra_gfx_romarb: latency, stale rom_ok, arbitration order,
// disabled requester, abort and asynchronous reset.
module tb_jtcontra_gfx_romarb;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [17:0] scr_a, obj_a;
  logic [5:0]  exp_obj;
  logic [15:0] last_obj_d;
  int          k;

  jtcontra_gfx_romarb_if bus ();

  jtcontra_gfx_romarb dut (
    .rst (rst),
    .clk (clk),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: observed no end of run, expected $finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rom_cs"},   32'(bus.rom_cs),      32'h0);
    check({tag, "_rom_addr"}, 32'(bus.rom_addr),    32'h0);
    check({tag, "_sel"},      32'(bus.rom_obj_sel), 32'h0);
    check({tag, "_scr_ok"},   32'(bus.scr_ok),      32'h0);
    check({tag, "_scr_data"}, 32'(bus.scr_data),    32'h0);
    check({tag, "_obj_ok"},   32'(bus.obj_ok),      32'h0);
    check({tag, "_obj_data"}, 32'(bus.obj_data),    32'h0);
    check({tag, "_busy"},     32'(bus.busy),        32'h0);
  endtask

  initial begin
    rst          = 1'b1;
    bus.gfx_en   = 2'b11;
    bus.scr_cs   = 1'b0;
    bus.scr_addr = '0;
    bus.obj_cs   = 1'b0;
    bus.obj_addr = '0;
    bus.rom_data = '0;
    bus.rom_ok   = 1'b0;
    tick(2);
    check_reset_vals("reset");
    rst = 1'b0;
    tick(1);

    // Test 1: single scr access, rom_ok two cycles after rom_cs
    bus.scr_cs   = 1'b1;
    bus.scr_addr = 18'h01234;
    tick(1);
    check("t1_rom_cs",   32'(bus.rom_cs),      32'h1);
    check("t1_rom_addr", 32'(bus.rom_addr),    32'h01234);
    check("t1_sel",      32'(bus.rom_obj_sel), 32'h0);
    check("t1_busy",     32'(bus.busy),        32'h1);
    check("t1_ok_early", 32'(bus.scr_ok),      32'h0);
    tick(1);
    check("t1_wait_cs",  32'(bus.rom_cs),      32'h1);
    check("t1_wait_ok",  32'(bus.scr_ok),      32'h0);
    tick(1);
    bus.rom_ok   = 1'b1;
    bus.rom_data = 16'hBEEF;
    tick(1);
    bus.rom_ok   = 1'b0;
    check("t1_scr_ok",   32'(bus.scr_ok),      32'h1);
    check("t1_scr_data", 32'(bus.scr_data),    32'hBEEF);
    check("t1_rom_cs0",  32'(bus.rom_cs),      32'h0);
    check("t1_busy0",    32'(bus.busy),        32'h0);
    check("t1_addr_hold",32'(bus.rom_addr),    32'h01234);
    tick(1);
    check("t1_ok_held",  32'(bus.scr_ok),      32'h1);
    // Address change while cs held: new request clears ok, then cs drop aborts in ISSUE
    bus.scr_addr = 18'h01235;
    tick(1);
    check("t1_new_ok0",  32'(bus.scr_ok),      32'h0);
    check("t1_new_cs",   32'(bus.rom_cs),      32'h1);
    check("t1_new_addr", 32'(bus.rom_addr),    32'h01235);
    bus.scr_cs = 1'b0;
    tick(1);
    check("t1_abort_cs", 32'(bus.rom_cs),      32'h0);
    check("t1_abort_bsy",32'(bus.busy),        32'h0);
    check("t1_abort_ok", 32'(bus.scr_ok),      32'h0);
    check("t1_abort_dat",32'(bus.scr_data),    32'hBEEF);

    // Test 2: stale rom_ok held high through ISSUE is ignored
    bus.scr_cs   = 1'b1;
    bus.scr_addr = 18'h00055;
    bus.rom_ok   = 1'b1;
    bus.rom_data = 16'h1111;
    tick(1);
    check("t2_issue_cs", 32'(bus.rom_cs),      32'h1);
    check("t2_issue_ok", 32'(bus.scr_ok),      32'h0);
    tick(1);
    check("t2_stale_ok", 32'(bus.scr_ok),      32'h0);
    check("t2_wait_cs",  32'(bus.rom_cs),      32'h1);
    bus.rom_data = 16'h2222;
    tick(1);
    bus.rom_ok   = 1'b0;
    check("t2_scr_ok",   32'(bus.scr_ok),      32'h1);
    check("t2_scr_data", 32'(bus.scr_data),    32'h2222);
    bus.scr_cs = 1'b0;
    tick(2);

    // Test 3: both requesters busy; grant order follows the arbitration mode
`ifdef JTCONTRA_ROMARB_RR_EN
    exp_obj = 6'b101010;
`else
    exp_obj = 6'b010000;
`endif
    last_obj_d   = 16'h0000;
    scr_a        = 18'h01000;
    obj_a        = 18'h02000;
    bus.scr_addr = scr_a;
    bus.obj_addr = obj_a;
    bus.scr_cs   = 1'b1;
    bus.obj_cs   = 1'b1;
    for (int g = 0; g < 6; g++) begin
      tick(1);
      k = 0;
      while (!bus.rom_cs && k < 8) begin
        tick(1);
        k++;
      end
      check("t3_grant_seen", 32'(bus.rom_cs),      32'h1);
      check("t3_grant_sel",  32'(bus.rom_obj_sel), 32'(exp_obj[g]));
      check("t3_grant_addr", 32'(bus.rom_addr),    exp_obj[g] ? 32'(obj_a) : 32'(scr_a));
      tick(1);
      bus.rom_ok   = 1'b1;
      bus.rom_data = 16'hA000 + 16'(g);
      tick(1);
      bus.rom_ok   = 1'b0;
      if (exp_obj[g]) begin
        last_obj_d = 16'hA000 + 16'(g);
        check("t3_obj_ok",   32'(bus.obj_ok),   32'h1);
        check("t3_obj_data", 32'(bus.obj_data), 32'(last_obj_d));
      end else begin
        check("t3_scr_ok",   32'(bus.scr_ok),   32'h1);
        check("t3_scr_data", 32'(bus.scr_data), 32'hA000 + 32'(g));
      end
      if (g == 5) begin
        bus.scr_cs = 1'b0;
        bus.obj_cs = 1'b0;
      end else if (exp_obj[g]) begin
        obj_a        = obj_a + 18'd1;
        bus.obj_addr = obj_a;
      end else begin
        scr_a        = scr_a + 18'd1;
        bus.scr_addr = scr_a;
      end
    end
    tick(2);
    check("t3_idle_cs",   32'(bus.rom_cs), 32'h0);
    check("t3_idle_busy", 32'(bus.busy),   32'h0);

    // Test 5: obj drops cs in WAIT; late rom_ok discarded; pending scr then served
    bus.obj_cs   = 1'b1;
    bus.obj_addr = 18'h00100;
    tick(1);
    check("t5_obj_cs",   32'(bus.rom_cs),      32'h1);
    check("t5_obj_sel",  32'(bus.rom_obj_sel), 32'h1);
    check("t5_obj_addr", 32'(bus.rom_addr),    32'h00100);
    bus.scr_cs   = 1'b1;
    bus.scr_addr = 18'h00200;
    tick(1);
    bus.obj_cs = 1'b0;
    tick(1);
    check("t5_abort_cs",  32'(bus.rom_cs), 32'h0);
    check("t5_abort_bsy", 32'(bus.busy),   32'h0);
    check("t5_abort_ok",  32'(bus.obj_ok), 32'h0);
    bus.rom_ok   = 1'b1;
    bus.rom_data = 16'hDEAD;
    tick(1);
    bus.rom_ok = 1'b0;
    check("t5_scr_cs",    32'(bus.rom_cs),      32'h1);
    check("t5_scr_addr",  32'(bus.rom_addr),    32'h00200);
    check("t5_scr_sel",   32'(bus.rom_obj_sel), 32'h0);
    check("t5_late_ok",   32'(bus.obj_ok),      32'h0);
    check("t5_obj_keep",  32'(bus.obj_data),    32'(last_obj_d));
    tick(1);
    bus.rom_ok   = 1'b1;
    bus.rom_data = 16'h3333;
    tick(1);
    bus.rom_ok = 1'b0;
    check("t5_scr_ok",    32'(bus.scr_ok),   32'h1);
    check("t5_scr_data",  32'(bus.scr_data), 32'h3333);
    check("t5_obj_ok0",   32'(bus.obj_ok),   32'h0);
    bus.scr_cs = 1'b0;
    tick(2);

    // Test 4: obj disabled, answered with zeros, no SDRAM access
    bus.gfx_en   = 2'b01;
    bus.obj_cs   = 1'b1;
    bus.obj_addr = 18'h00777;
    tick(1);
    check("t4_obj_ok",   32'(bus.obj_ok),   32'h1);
    check("t4_obj_data", 32'(bus.obj_data), 32'h0);
    for (int i = 0; i < 3; i++) begin
      check("t4_sel",    32'(bus.rom_obj_sel), 32'h0);
      check("t4_rom_cs", 32'(bus.rom_cs),      32'h0);
      tick(1);
    end
    bus.obj_cs = 1'b0;
    bus.gfx_en = 2'b11;
    tick(2);

    // Test 6: asynchronous reset in WAIT
    bus.scr_cs   = 1'b1;
    bus.scr_addr = 18'h00300;
    tick(2);
    check("t6_wait_busy", 32'(bus.busy), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("t6_async");
    bus.scr_cs = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(2);
    check("t6_idle_cs",   32'(bus.rom_cs), 32'h0);
    check("t6_idle_busy", 32'(bus.busy),   32'h0);
    bus.scr_cs   = 1'b1;
    bus.scr_addr = 18'h00400;
    tick(1);
    check("t6_new_cs",    32'(bus.rom_cs),   32'h1);
    check("t6_new_addr",  32'(bus.rom_addr), 32'h00400);
    bus.scr_cs = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
